binary_box_detect: RTL and testbench

Per-frame bounding-box detector sitting directly downstream of the binarization stage. Consumes the 1-bit foreground stream (1 = foreground) with its vsync/href/clken qualifiers, tracks the minimum and maximum column and row of foreground pixels across one frame, and presents the box with a one-cycle valid pulse at frame end. The synchronization signals and the bit are also forwarded with one cycle of delay for downstream overlay/recognition logic.

---
 rtl/binary_box_detect_if.sv | 33 +++
 rtl/binary_box_detect.sv | 218 +++++++++++++++++++++
 tb/tb_binary_box_detect.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/binary_box_detect_if.sv
// Pixel-stream bundle for binary_box_detect: the binarized input stream, its
// 1-cycle delayed copy and the per-frame bounding-box results.
interface binary_box_detect_if #(
    parameter int H_W = 11,
    parameter int V_W = 11
);
    logic           per_frame_vsync;
    logic           per_frame_href;
    logic           per_frame_clken;
    logic           per_img_Bit;
    logic           post_frame_vsync;
    logic           post_frame_href;
    logic           post_frame_clken;
    logic           post_img_Bit;
    logic           box_valid;
    logic           box_found;
    logic [H_W-1:0] box_x_min;
    logic [H_W-1:0] box_x_max;
    logic [V_W-1:0] box_y_min;
    logic [V_W-1:0] box_y_max;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit,
        input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
        input  box_valid, box_found, box_x_min, box_x_max, box_y_min, box_y_max
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit,
        output post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
        output box_valid, box_found, box_x_min, box_x_max, box_y_min, box_y_max
    );
endinterface

// File: rtl/binary_box_detect.sv
// Per-frame bounding box of foreground pixels in a 1-bit video stream.
// Define BBOX_MINCNT_EN to require at least MIN_COUNT foreground pixels per box.
module binary_box_detect #(
    parameter int H_W       = 11,
    parameter int V_W       = 11,
    parameter int MIN_COUNT = 16
) (
    input logic                clk,
    input logic                rst,
    binary_box_detect_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [H_W-1:0] X_ALL  = {H_W{1'b1}};
    localparam logic [H_W-1:0] X_ZERO = {H_W{1'b0}};
    localparam logic [H_W-1:0] X_ONE  = {{(H_W-1){1'b0}}, 1'b1};
    localparam logic [V_W-1:0] Y_ALL  = {V_W{1'b1}};
    localparam logic [V_W-1:0] Y_ZERO = {V_W{1'b0}};
    localparam logic [V_W-1:0] Y_ONE  = {{(V_W-1){1'b0}}, 1'b1};

    state_t         state_r, state_nxt_s;
    logic           vsync_r, href_r, clken_r, bit_r;
    logic           pix_s, fg_s, rise_s, fall_s;
    logic           start_s, done_s, upd_s, found_s;
    logic [H_W-1:0] x_cnt_r, x_min_r, x_max_r;
    logic [H_W-1:0] x_min_base_s, x_max_base_s, x_min_nxt_s, x_max_nxt_s;
    logic [V_W-1:0] y_cnt_r, y_min_r, y_max_r;
    logic [V_W-1:0] y_min_base_s, y_max_base_s, y_min_nxt_s, y_max_nxt_s;
    logic           box_valid_r, box_found_r;
    logic [H_W-1:0] box_x_min_r, box_x_max_r;
    logic [V_W-1:0] box_y_min_r, box_y_max_r;

    assign pix_s  = bus.per_frame_vsync & bus.per_frame_href & bus.per_frame_clken;
    assign fg_s   = pix_s & bus.per_img_Bit;
    assign rise_s = bus.per_frame_vsync & ~vsync_r;
    assign fall_s = ~bus.per_frame_vsync & vsync_r;
    // A pixel on the very cycle vsync rises belongs to the new frame.
    assign upd_s  = fg_s & (start_s | (state_r == ACTIVE));

    // Input pass-through delay; vsync_r/href_r double as edge-detect history
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_r <= 1'b0;
            href_r  <= 1'b0;
            clken_r <= 1'b0;
            bit_r   <= 1'b0;
        end else begin
            vsync_r <= bus.per_frame_vsync;
            href_r  <= bus.per_frame_href;
            clken_r <= bus.per_frame_clken;
            bit_r   <= bus.per_img_Bit;
        end
    end

    // Column counter: counts enabled pixels within a line, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt_r <= X_ZERO;
        end else if (!bus.per_frame_href) begin
            x_cnt_r <= X_ZERO;
        end else if (pix_s && (x_cnt_r != X_ALL)) begin
            x_cnt_r <= x_cnt_r + X_ONE;
        end else begin
            x_cnt_r <= x_cnt_r;
        end
    end

    // Row counter: advances on each line end inside the frame, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            y_cnt_r <= Y_ZERO;
        end else if (!bus.per_frame_vsync) begin
            y_cnt_r <= Y_ZERO;
        end else if (href_r && !bus.per_frame_href && (y_cnt_r != Y_ALL)) begin
            y_cnt_r <= y_cnt_r + Y_ONE;
        end else begin
            y_cnt_r <= y_cnt_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and frame start/end strobes
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_nxt_s = ACTIVE;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACTIVE: begin
                if (fall_s) begin
                    state_nxt_s = DONE;
                    done_s      = 1'b1;
                end else begin
                    state_nxt_s = ACTIVE;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Accumulators restart from empty-box values at frame start, then fold in the pixel
    assign x_min_base_s = start_s ? X_ALL  : x_min_r;
    assign x_max_base_s = start_s ? X_ZERO : x_max_r;
    assign y_min_base_s = start_s ? Y_ALL  : y_min_r;
    assign y_max_base_s = start_s ? Y_ZERO : y_max_r;
    assign x_min_nxt_s  = (upd_s && (x_cnt_r < x_min_base_s)) ? x_cnt_r : x_min_base_s;
    assign x_max_nxt_s  = (upd_s && (x_cnt_r > x_max_base_s)) ? x_cnt_r : x_max_base_s;
    assign y_min_nxt_s  = (upd_s && (y_cnt_r < y_min_base_s)) ? y_cnt_r : y_min_base_s;
    assign y_max_nxt_s  = (upd_s && (y_cnt_r > y_max_base_s)) ? y_cnt_r : y_max_base_s;

`ifdef BBOX_MINCNT_EN
    localparam logic [19:0] CNT_ALL   = 20'hFFFFF;
    localparam logic [19:0] CNT_ONE   = 20'd1;
    localparam logic [19:0] MIN_CNT_L = 20'(MIN_COUNT);

    logic [19:0] cnt_r, cnt_base_s, cnt_nxt_s;

    assign cnt_base_s = start_s ? 20'd0 : cnt_r;
    assign cnt_nxt_s  = (upd_s && (cnt_base_s != CNT_ALL)) ? (cnt_base_s + CNT_ONE) : cnt_base_s;
    assign found_s    = (cnt_r >= MIN_CNT_L);

    // Foreground pixel counter for noise rejection
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 20'd0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`else
    logic seen_r, seen_nxt_s;

    assign seen_nxt_s = (start_s ? 1'b0 : seen_r) | upd_s;
    assign found_s    = seen_r;

    // Any-foreground flag for the current frame
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_r <= 1'b0;
        end else begin
            seen_r <= seen_nxt_s;
        end
    end
`endif

    // Min/max accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            x_min_r <= X_ZERO;
            x_max_r <= X_ZERO;
            y_min_r <= Y_ZERO;
            y_max_r <= Y_ZERO;
        end else begin
            x_min_r <= x_min_nxt_s;
            x_max_r <= x_max_nxt_s;
            y_min_r <= y_min_nxt_s;
            y_max_r <= y_max_nxt_s;
        end
    end

    // Result registers load on entry to DONE so the pulse lands one cycle after vsync falls
    always_ff @(posedge clk) begin
        if (rst) begin
            box_valid_r <= 1'b0;
            box_found_r <= 1'b0;
            box_x_min_r <= X_ZERO;
            box_x_max_r <= X_ZERO;
            box_y_min_r <= Y_ZERO;
            box_y_max_r <= Y_ZERO;
        end else if (done_s) begin
            box_valid_r <= 1'b1;
            box_found_r <= found_s;
            box_x_min_r <= found_s ? x_min_r : X_ZERO;
            box_x_max_r <= found_s ? x_max_r : X_ZERO;
            box_y_min_r <= found_s ? y_min_r : Y_ZERO;
            box_y_max_r <= found_s ? y_max_r : Y_ZERO;
        end else begin
            box_valid_r <= 1'b0;
        end
    end

    assign bus.post_frame_vsync = vsync_r;
    assign bus.post_frame_href  = href_r;
    assign bus.post_frame_clken = clken_r;
    assign bus.post_img_Bit     = bit_r;
    assign bus.box_valid        = box_valid_r;
    assign bus.box_found        = box_found_r;
    assign bus.box_x_min        = box_x_min_r;
    assign bus.box_x_max        = box_x_max_r;
    assign bus.box_y_min        = box_y_min_r;
    assign bus.box_y_max        = box_y_max_r;

endmodule

// File: tb/tb_binary_box_detect.sv
// Directed bench for binary_box_detect: 8x4 frames, expected boxes queued per frame
// and compared when box_valid is due; pass-through and held outputs checked every cycle.
module tb_binary_box_detect;

    localparam int H_W       = 11;
    localparam int V_W       = 11;
    localparam int MIN_COUNT = 16;

    typedef struct packed {
        logic           found;
        logic [H_W-1:0] x0;
        logic [H_W-1:0] x1;
        logic [V_W-1:0] y0;
        logic [V_W-1:0] y1;
    } box_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    binary_box_detect_if #(.H_W(H_W), .V_W(V_W)) bus ();

    binary_box_detect #(.H_W(H_W), .V_W(V_W), .MIN_COUNT(MIN_COUNT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    box_t exp_q[$];
    box_t exp_cur;
    int   errors = 0;
    int   checks = 0;
    logic prev_v;
    logic in_frame;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, check outputs at the next falling edge
    task automatic tick(input logic v, input logic h, input logic c, input logic b);
        logic exp_valid;
        box_t obs;
        bus.per_frame_vsync = v;
        bus.per_frame_href  = h;
        bus.per_frame_clken = c;
        bus.per_img_Bit     = b;
        exp_valid = 1'b0;
        if (rst) begin
            prev_v   = 1'b0;
            in_frame = 1'b0;
            exp_cur  = '0;
        end else begin
            if (v && !prev_v) begin
                in_frame = 1'b1;
            end else if (!v && prev_v && in_frame) begin
                exp_valid = 1'b1;
                in_frame  = 1'b0;
            end
            prev_v = v;
        end
        @(negedge clk);
        chk("post", 64'({bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken, bus.post_img_Bit}),
            64'(rst ? 4'b0000 : {v, h, c, b}));
        chk("box_valid", 64'(bus.box_valid), 64'(exp_valid));
        if (exp_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL scoreboard observed=empty expected=entry");
            end
            if (exp_q.size() != 0) exp_cur = exp_q.pop_front();
        end
        obs = {bus.box_found, bus.box_x_min, bus.box_x_max, bus.box_y_min, bus.box_y_max};
        chk("box", 64'(obs), 64'(exp_cur));
    endtask

    // Queue the expected box for an 8x4 map (bit y*8+x) and stream the frame
    task automatic send_frame(input logic [31:0] map, input bit gaps);
        box_t e;
        int   n;
        logic found;
        e = '0;
        n = 0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                if (map[y*8+x]) begin
                    if (n == 0) begin
                        e.x0 = H_W'(x); e.x1 = H_W'(x); e.y0 = V_W'(y); e.y1 = V_W'(y);
                    end else begin
                        if (H_W'(x) < e.x0) e.x0 = H_W'(x);
                        if (H_W'(x) > e.x1) e.x1 = H_W'(x);
                        if (V_W'(y) < e.y0) e.y0 = V_W'(y);
                        if (V_W'(y) > e.y1) e.y1 = V_W'(y);
                    end
                    n++;
                end
            end
        end
`ifdef BBOX_MINCNT_EN
        found = (n >= MIN_COUNT);
`else
        found = (n > 0);
`endif
        if (!found) e = '0;
        e.found = found;
        exp_q.push_back(e);

        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                if (gaps) tick(1'b1, 1'b1, 1'b0, 1'b1);
                tick(1'b1, 1'b1, 1'b1, map[y*8+x]);
            end
            tick(1'b1, 1'b0, 1'b1, 1'b1);
            tick(1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        exp_cur  = '0;
        prev_v   = 1'b0;
        in_frame = 1'b0;
        rst      = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Two foreground pixels: (2,1) and (5,3)
        send_frame(32'h2000_0400, 1'b0);
        // Empty frame overwrites the previous box with zeros
        send_frame(32'h0000_0000, 1'b0);
        // clken gaps inside lines and spurious clken on blanking: (3,0) and (7,2)
        send_frame(32'h0080_0008, 1'b1);

        // Reset in the middle of a frame after foreground at (1,1)
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int x = 0; x < 8; x++) tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        // Clean frame with foreground at (6,2) only
        send_frame(32'h0040_0000, 1'b0);

        // 15 then 16 foreground pixels in rows 1..2
        send_frame(32'h00FE_FF00, 1'b0);
        send_frame(32'h00FF_FF00, 1'b0);

        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
